// File: rtl/ysyx_25020051_key_cam.sv
// ysyx_25020051_key_cam: reverse (data -> key) lookup over a small writable CAM,
// with a one-deep registered result stage behind valid/ready handshakes.
`default_nettype none

module ysyx_25020051_key_cam #(
  parameter  int NR_ENTRY = 8,
  parameter  int KEY_LEN  = 4,
  parameter  int DATA_LEN = 32,
  localparam int IDX_W    = $clog2(NR_ENTRY)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                clr_all,
  input  logic [KEY_LEN-1:0]  default_key,
  input  logic                q_valid,
  output logic                q_ready,
  input  logic [DATA_LEN-1:0] q_data,
  output logic                r_valid,
  input  logic                r_ready,
  output logic                r_hit,
  output logic [KEY_LEN-1:0]  r_key,
  output logic [IDX_W-1:0]    r_idx,
  output logic                r_multi
);

  logic [KEY_LEN-1:0]  key_q  [NR_ENTRY];
  logic [DATA_LEN-1:0] data_q [NR_ENTRY];
  logic [NR_ENTRY-1:0] valid_q, valid_d;

  logic                r_valid_q, r_valid_d;
  logic                r_hit_q,   r_hit_d;
  logic [KEY_LEN-1:0]  r_key_q,   r_key_d;
  logic [IDX_W-1:0]    r_idx_q,   r_idx_d;
  logic                r_multi_q, r_multi_d;

  logic                wr_ok;
  logic                accept;
  logic [NR_ENTRY-1:0] match;
  logic                hit;
  logic                multi;
  logic [IDX_W-1:0]    hit_idx;

  assign wr_ok   = wr_en && !clr_all && (32'(wr_idx) < 32'(NR_ENTRY));
  assign q_ready = !r_valid_q || r_ready;
  assign accept  = q_valid && q_ready;

  // Compare uses the pre-edge table, so a same-cycle write/clear is invisible.
  always_comb begin
    hit     = 1'b0;
    multi   = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < NR_ENTRY; i++) begin
      match[i] = valid_q[i] && (data_q[i] == q_data);
      if (match[i]) begin
        if (hit) begin
          multi = 1'b1;
        end else begin
          hit     = 1'b1;
          hit_idx = IDX_W'(i);
        end
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (clr_all) begin
      valid_d = '0;
    end else if (wr_ok) begin
      valid_d[wr_idx] = 1'b1;
    end
  end

  always_comb begin
    r_valid_d = r_valid_q;
    r_hit_d   = r_hit_q;
    r_key_d   = r_key_q;
    r_idx_d   = r_idx_q;
    r_multi_d = r_multi_q;
    if (accept) begin
      r_valid_d = 1'b1;
      r_hit_d   = hit;
      r_key_d   = hit ? key_q[hit_idx] : default_key;
      r_idx_d   = hit_idx;
      r_multi_d = multi;
    end else if (r_ready) begin
      r_valid_d = 1'b0;
    end
  end

  // Storage is left unreset; the valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      key_q[wr_idx]  <= wr_key;
      data_q[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      r_valid_q <= 1'b0;
      r_hit_q   <= 1'b0;
      r_key_q   <= '0;
      r_idx_q   <= '0;
      r_multi_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      r_valid_q <= r_valid_d;
      r_hit_q   <= r_hit_d;
      r_key_q   <= r_key_d;
      r_idx_q   <= r_idx_d;
      r_multi_q <= r_multi_d;
    end
  end

  assign r_valid = r_valid_q;
  assign r_hit   = r_hit_q;
  assign r_key   = r_key_q;
  assign r_idx   = r_idx_q;
  assign r_multi = r_multi_q;

endmodule

`default_nettype wire
